// File: rtl/bias_add_ctrl_if.sv
// rtl/bias_add_ctrl_if.sv - row streams into and out of the bias-add stage.
// The master side is upstream array plus downstream writeback; the slave side is bias_add_ctrl.
interface bias_add_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N_ELEM     = 4
);
  logic                         in_valid;
  logic                         in_ready;
  logic [N_ELEM*DATA_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [N_ELEM*DATA_WIDTH-1:0] out_data;
  logic                         out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/bias_add_ctrl.sv
// rtl/bias_add_ctrl.sv - double-buffered per-column bias add on the array output stream.
// Define BIAS_ADD_CTRL_SATURATE_EN to clamp sums on signed overflow instead of wrapping.
module bias_add_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int N_ELEM        = 4,
  parameter int ROWS_PER_TILE = 4,
  parameter int IDX_W         = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_wr_en,
  input  logic [IDX_W-1:0]      cfg_wr_idx,
  input  logic [DATA_WIDTH-1:0] cfg_wr_data,
  input  logic                  cfg_commit,
  output logic                  cfg_busy,
  bias_add_ctrl_if.slave        s
);

  localparam int CNT_W = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS_PER_TILE - 1);

  typedef enum logic [1:0] {S_NOBIAS, S_RUN, S_PEND} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        row_cnt_q, row_cnt_d;
  logic [DATA_WIDTH-1:0]   shadow_q [N_ELEM];
  logic [DATA_WIDTH-1:0]   shadow_d [N_ELEM];
  logic [DATA_WIDTH-1:0]   active_q [N_ELEM];
  logic [DATA_WIDTH-1:0]   active_d [N_ELEM];
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [N_ELEM*DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                    busy_q, busy_d;

  logic                    in_ready;
  logic                    accept;
  logic                    last_row;
  logic                    swap;
  logic [DATA_WIDTH:0]     wide [N_ELEM];
  logic [N_ELEM*DATA_WIDTH-1:0] sum_row;

  assign in_ready   = (state_q != S_NOBIAS) && (!out_valid_q || s.out_ready);
  assign accept     = s.in_valid && in_ready;
  assign last_row   = (row_cnt_q == LAST_ROW);

  assign s.in_ready  = in_ready;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign s.out_last  = out_last_q;
  assign cfg_busy    = busy_q;

  // Sum uses one extra bit so overflow is visible as a mismatch of the top two bits.
  always_comb begin
    sum_row = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      wide[i] = {s.in_data[i*DATA_WIDTH + DATA_WIDTH - 1], s.in_data[i*DATA_WIDTH +: DATA_WIDTH]}
              + {active_q[i][DATA_WIDTH-1], active_q[i]};
`ifdef BIAS_ADD_CTRL_SATURATE_EN
      if (wide[i][DATA_WIDTH] != wide[i][DATA_WIDTH-1]) begin
        sum_row[i*DATA_WIDTH +: DATA_WIDTH] = wide[i][DATA_WIDTH]
            ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
            : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else begin
        sum_row[i*DATA_WIDTH +: DATA_WIDTH] = wide[i][DATA_WIDTH-1:0];
      end
`else
      sum_row[i*DATA_WIDTH +: DATA_WIDTH] = wide[i][DATA_WIDTH-1:0];
`endif
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    if (cfg_wr_en && (state_q != S_PEND) && (int'(cfg_wr_idx) < N_ELEM)) begin
      shadow_d[cfg_wr_idx] = cfg_wr_data;
    end

    swap    = 1'b0;
    state_d = state_q;
    case (state_q)
      S_NOBIAS: begin
        if (cfg_commit) begin
          swap    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Swap now only at a clean tile boundary; anything mid-tile waits for the last row.
        if (cfg_commit) begin
          if ((row_cnt_q == '0 && !accept) || (accept && last_row)) begin
            swap = 1'b1;
          end else begin
            state_d = S_PEND;
          end
        end
      end
      S_PEND: begin
        if (accept && last_row) begin
          swap    = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_NOBIAS;
    endcase

    active_d = swap ? shadow_d : active_q;

    row_cnt_d   = row_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (accept) begin
      row_cnt_d   = last_row ? '0 : row_cnt_q + 1'b1;
      out_valid_d = 1'b1;
      out_last_d  = last_row;
      out_data_d  = sum_row;
    end else if (s.out_ready) begin
      out_valid_d = 1'b0;
    end

    busy_d = (state_d == S_PEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_NOBIAS;
      row_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      for (int i = 0; i < N_ELEM; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
    end
  end

endmodule
